// File: rtl/reset_sequencer.sv
// reset_sequencer
// Multi-channel peripheral reset controller. Releases up to 16 active-low
// peripheral resets in a staggered order, gates trigger-mode channels from an
// internal or external acquisition trigger, enforces a watchdog timeout and an
// instant-reset fault (latched until cleared), and produces the alive
// heartbeat and the master trigger for slave boards.
//
// Ports:
//   clk                       system clock
//   peripheral_aresetn        asynchronous active-low reset
//   cfg_trigger_mask[N]       1: channel follows trigger, 0: continuous
//   cfg_fault_mask[N]         1: channel forced into reset during FAULT
//   cfg_ext_trigger           0: internal trigger source, 1: external
//   cfg_trigger_enable        enables the internal trigger
//   cfg_watchdog_enable       enables the watchdog timeout
//   cfg_instant_reset_enable  enables the instant-reset input
//   cfg_fault_clear           rising edge requests exit from FAULT
//   counter_trigger           internal trigger from the counter block
//   trigger_in, watchdog_in, instant_reset_in   asynchronous DIO inputs
//   ch_aresetn[N]             per-channel active-low resets
//   reset_ack                 high while in FAULT
//   alive_signal              heartbeat
//   master_trigger            internal trigger for slave boards
//   status[31:0]              status word
module reset_sequencer #(
  parameter int NUM_CHANNELS            = 4,
  parameter int SYNC_STAGES             = 2,
  parameter int RELEASE_STAGGER_CYCLES  = 16,
  parameter int WATCHDOG_TIMEOUT_CYCLES = 1250000,
  parameter int ALIVE_LOW_CYCLES        = 12500000,
  parameter int ALIVE_HIGH_CYCLES       = 1250000
) (
  input  logic                    clk,
  input  logic                    peripheral_aresetn,
  input  logic [NUM_CHANNELS-1:0] cfg_trigger_mask,
  input  logic [NUM_CHANNELS-1:0] cfg_fault_mask,
  input  logic                    cfg_ext_trigger,
  input  logic                    cfg_trigger_enable,
  input  logic                    cfg_watchdog_enable,
  input  logic                    cfg_instant_reset_enable,
  input  logic                    cfg_fault_clear,
  input  logic                    counter_trigger,
  input  logic                    trigger_in,
  input  logic                    watchdog_in,
  input  logic                    instant_reset_in,
  output logic [NUM_CHANNELS-1:0] ch_aresetn,
  output logic                    reset_ack,
  output logic                    alive_signal,
  output logic                    master_trigger,
  output logic [31:0]             status
);

  localparam int STG_LAST  = (NUM_CHANNELS - 1) * RELEASE_STAGGER_CYCLES;
  localparam int STG_W     = $clog2(STG_LAST + 2);
  localparam int WD_W      = $clog2(WATCHDOG_TIMEOUT_CYCLES + 1);
  localparam int HB_PERIOD = ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES;
  localparam int HB_W      = $clog2(HB_PERIOD + 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  logic [1:0]              rst_sync_r;
  logic [SYNC_STAGES-1:0]  trig_sync_r;
  logic [SYNC_STAGES-1:0]  wd_sync_r;
  logic [SYNC_STAGES-1:0]  ir_sync_r;
  logic                    trigger_sync_s;
  logic                    wd_sync_s;
  logic                    ir_sync_s;
  logic                    trigger_state_r;
  logic                    wd_prev_r;
  logic                    clr_prev_r;
  logic                    clr_edge_r;
  logic [1:0]              mt_pipe_r;
  state_t                  state_r;
  logic [STG_W-1:0]        stg_cnt_r;
  logic [WD_W-1:0]         wd_cnt_r;
  logic [HB_W-1:0]         hb_cnt_r;
  logic                    cause_wd_r;
  logic                    cause_ir_r;
  logic                    wd_toggle_s;
  logic                    wd_fire_s;
  logic                    ir_fire_s;
  logic [NUM_CHANNELS-1:0] ch_next_s;
  logic [31:0]             status_s;
  logic [NUM_CHANNELS-1:0] ch_r;
  logic                    reset_ack_r;
  logic                    alive_r;
  logic [31:0]             status_r;

  assign trigger_sync_s = trig_sync_r[SYNC_STAGES-1];
  assign wd_sync_s      = wd_sync_r[SYNC_STAGES-1];
  assign ir_sync_s      = ir_sync_r[SYNC_STAGES-1];

  // Internal reset: asserts immediately, releases two clocks after the pin.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Synchronisers for the asynchronous DIO inputs.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      trig_sync_r <= '0;
      wd_sync_r   <= '0;
      ir_sync_r   <= '0;
    end else begin
      trig_sync_r <= {trig_sync_r[SYNC_STAGES-2:0], trigger_in};
      wd_sync_r   <= {wd_sync_r[SYNC_STAGES-2:0], watchdog_in};
      ir_sync_r   <= {ir_sync_r[SYNC_STAGES-2:0], instant_reset_in};
    end
  end

  // Trigger selection, edge-detect history and master trigger pipeline.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      trigger_state_r <= 1'b0;
      wd_prev_r       <= 1'b0;
      clr_prev_r      <= 1'b0;
      clr_edge_r      <= 1'b0;
      mt_pipe_r       <= 2'b00;
    end else begin
      trigger_state_r <= cfg_ext_trigger ? trigger_sync_s
                                         : (cfg_trigger_enable & counter_trigger);
      wd_prev_r       <= wd_sync_s;
      clr_prev_r      <= cfg_fault_clear;
      clr_edge_r      <= cfg_fault_clear & ~clr_prev_r;
      mt_pipe_r       <= {mt_pipe_r[0], cfg_trigger_enable & counter_trigger};
    end
  end

  // Fault conditions. The watchdog fires on the cycle its counter would reach
  // TIMEOUT-1, so the FSM enters FAULT exactly TIMEOUT cycles after the last
  // synchronised toggle (the toggle itself is seen one cycle after it lands).
  always_comb begin
    wd_toggle_s = wd_sync_s ^ wd_prev_r;
    wd_fire_s   = 1'b0;
    if ((state_r == ST_RUN) && cfg_watchdog_enable && !wd_toggle_s &&
        (wd_cnt_r == WD_W'(WATCHDOG_TIMEOUT_CYCLES - 2))) begin
      wd_fire_s = 1'b1;
    end else begin
      wd_fire_s = 1'b0;
    end
    ir_fire_s = (state_r == ST_RUN) & ir_sync_s & cfg_instant_reset_enable;
  end

  // Sequencer FSM with stagger counter and latched fault cause.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state_r    <= ST_HOLD;
      stg_cnt_r  <= '0;
      cause_wd_r <= 1'b0;
      cause_ir_r <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          stg_cnt_r <= '0;
          if (rst_sync_r[1]) begin
            state_r <= ST_STAGGER;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_STAGGER: begin
          if (stg_cnt_r == STG_W'(STG_LAST)) begin
            state_r <= ST_RUN;
          end else begin
            stg_cnt_r <= stg_cnt_r + STG_W'(1);
          end
        end
        ST_RUN: begin
          if (wd_fire_s || ir_fire_s) begin
            state_r    <= ST_FAULT;
            cause_wd_r <= wd_fire_s;
            cause_ir_r <= ir_fire_s;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FAULT: begin
          // Only an explicit clear leaves FAULT, and never while the
          // instant-reset input is still asserted.
          if (clr_edge_r && !ir_sync_s) begin
            state_r    <= ST_RUN;
            cause_wd_r <= 1'b0;
            cause_ir_r <= 1'b0;
          end else begin
            state_r <= ST_FAULT;
          end
        end
        default: begin
          state_r <= ST_HOLD;
        end
      endcase
    end
  end

  // Watchdog counter: live only while enabled in RUN, cleared by any toggle.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      wd_cnt_r <= '0;
    end else if ((state_r == ST_RUN) && cfg_watchdog_enable) begin
      if (wd_toggle_s) begin
        wd_cnt_r <= '0;
      end else begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
    end else begin
      wd_cnt_r <= '0;
    end
  end

  // Free-running heartbeat counter.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      hb_cnt_r <= '0;
    end else if (hb_cnt_r == HB_W'(HB_PERIOD - 1)) begin
      hb_cnt_r <= '0;
    end else begin
      hb_cnt_r <= hb_cnt_r + HB_W'(1);
    end
  end

  // Next channel reset values and status word.
  always_comb begin
    ch_next_s = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      case (state_r)
        ST_HOLD: begin
          ch_next_s[i] = 1'b0;
        end
        ST_STAGGER: begin
          if (cfg_trigger_mask[i]) begin
            ch_next_s[i] = 1'b0;
          end else begin
            ch_next_s[i] = (32'(stg_cnt_r) >= 32'(i * RELEASE_STAGGER_CYCLES));
          end
        end
        ST_RUN: begin
          ch_next_s[i] = cfg_trigger_mask[i] ? trigger_state_r : 1'b1;
        end
        ST_FAULT: begin
          if (cfg_fault_mask[i]) begin
            ch_next_s[i] = 1'b0;
          end else begin
            ch_next_s[i] = cfg_trigger_mask[i] ? trigger_state_r : 1'b1;
          end
        end
        default: begin
          ch_next_s[i] = 1'b0;
        end
      endcase
    end

    status_s                     = 32'd0;
    status_s[1:0]                = state_r;
    status_s[2]                  = trigger_state_r;
    status_s[3]                  = wd_sync_s;
    status_s[4]                  = ir_sync_s;
    status_s[5]                  = cause_wd_r;
    status_s[6]                  = cause_ir_r;
    status_s[7]                  = cfg_watchdog_enable;
    status_s[16 +: NUM_CHANNELS] = ch_next_s;
  end

  // Output registers.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      ch_r        <= '0;
      reset_ack_r <= 1'b0;
      alive_r     <= 1'b0;
      status_r    <= 32'd0;
    end else begin
      ch_r        <= ch_next_s;
      reset_ack_r <= (state_r == ST_FAULT);
      alive_r     <= (hb_cnt_r >= HB_W'(ALIVE_LOW_CYCLES));
      status_r    <= status_s;
    end
  end

  assign ch_aresetn     = ch_r;
  assign reset_ack      = reset_ack_r;
  assign alive_signal   = alive_r;
  assign master_trigger = mt_pipe_r[1];
  assign status         = status_r;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic        clk = 1'b0;
  logic        peripheral_aresetn = 1'b0;
  logic [3:0]  cfg_trigger_mask = 4'b0000;
  logic [3:0]  cfg_fault_mask = 4'b0000;
  logic        cfg_ext_trigger = 1'b0;
  logic        cfg_trigger_enable = 1'b0;
  logic        cfg_watchdog_enable = 1'b0;
  logic        cfg_instant_reset_enable = 1'b0;
  logic        cfg_fault_clear = 1'b0;
  logic        counter_trigger = 1'b1;
  logic        trigger_in = 1'b0;
  logic        watchdog_in = 1'b0;
  logic        instant_reset_in = 1'b0;
  logic [3:0]  ch_aresetn;
  logic        reset_ack;
  logic        alive_signal;
  logic        master_trigger;
  logic [31:0] status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CHANNELS(4),
    .SYNC_STAGES(2),
    .RELEASE_STAGGER_CYCLES(16),
    .WATCHDOG_TIMEOUT_CYCLES(100),
    .ALIVE_LOW_CYCLES(10),
    .ALIVE_HIGH_CYCLES(3)
  ) dut (
    .clk(clk),
    .peripheral_aresetn(peripheral_aresetn),
    .cfg_trigger_mask(cfg_trigger_mask),
    .cfg_fault_mask(cfg_fault_mask),
    .cfg_ext_trigger(cfg_ext_trigger),
    .cfg_trigger_enable(cfg_trigger_enable),
    .cfg_watchdog_enable(cfg_watchdog_enable),
    .cfg_instant_reset_enable(cfg_instant_reset_enable),
    .cfg_fault_clear(cfg_fault_clear),
    .counter_trigger(counter_trigger),
    .trigger_in(trigger_in),
    .watchdog_in(watchdog_in),
    .instant_reset_in(instant_reset_in),
    .ch_aresetn(ch_aresetn),
    .reset_ack(reset_ack),
    .alive_signal(alive_signal),
    .master_trigger(master_trigger),
    .status(status)
  );

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    peripheral_aresetn = 1'b0;
    wait_neg(3);
    checks++; if (ch_aresetn !== 4'b0000) begin failures++; $display("FAIL reset_ch got=%b exp=0000", ch_aresetn); end
    checks++; if (reset_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", reset_ack); end
    checks++; if (alive_signal !== 1'b0) begin failures++; $display("FAIL reset_alive got=%b exp=0", alive_signal); end
    checks++; if (master_trigger !== 1'b0) begin failures++; $display("FAIL reset_master got=%b exp=0", master_trigger); end
    checks++; if (status !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=00000000", status); end
  endtask

  // Release at a falling edge; channel i rises 4+16*i rising edges later
  // (2 reset-sync, 1 HOLD->STAGGER, 1 output register).
  task automatic test_stagger;
    logic [3:0] exp;
    peripheral_aresetn = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) exp[i] = (k >= 4 + 16 * i);
      checks++; if (ch_aresetn !== exp) begin failures++; $display("FAIL stagger_ch k=%0d got=%b exp=%b", k, ch_aresetn, exp); end
      if (k == 52) begin
        checks++; if (status[1:0] !== 2'd1) begin failures++; $display("FAIL stagger_state k=52 got=%0d exp=1", status[1:0]); end
      end
      if (k == 53) begin
        checks++; if (status[1:0] !== 2'd2) begin failures++; $display("FAIL run_state k=53 got=%0d exp=2", status[1:0]); end
      end
    end
    checks++; if (status[19:16] !== 4'hF) begin failures++; $display("FAIL status_ch got=%h exp=f", status[19:16]); end
  endtask

  task automatic test_trigger_ext;
    cfg_trigger_mask = 4'b0011;
    cfg_ext_trigger = 1'b1;
    trigger_in = 1'b0;
    wait_neg(10);
    checks++; if (ch_aresetn !== 4'b1100) begin failures++; $display("FAIL ext_idle got=%b exp=1100", ch_aresetn); end
    trigger_in = 1'b1;
    wait_neg(3);
    checks++; if (ch_aresetn !== 4'b1100) begin failures++; $display("FAIL ext_rise_early got=%b exp=1100", ch_aresetn); end
    wait_neg(1);
    checks++; if (ch_aresetn !== 4'b1111) begin failures++; $display("FAIL ext_rise got=%b exp=1111", ch_aresetn); end
    checks++; if (status[2] !== 1'b1) begin failures++; $display("FAIL ext_status_trig got=%b exp=1", status[2]); end
    wait_neg(4);
    trigger_in = 1'b0;
    wait_neg(3);
    checks++; if (ch_aresetn !== 4'b1111) begin failures++; $display("FAIL ext_fall_early got=%b exp=1111", ch_aresetn); end
    wait_neg(1);
    checks++; if (ch_aresetn !== 4'b1100) begin failures++; $display("FAIL ext_fall got=%b exp=1100", ch_aresetn); end
  endtask

  task automatic test_trigger_int;
    cfg_ext_trigger = 1'b0;
    cfg_trigger_enable = 1'b1;
    counter_trigger = 1'b0;
    wait_neg(5);
    checks++; if (ch_aresetn !== 4'b1100) begin failures++; $display("FAIL int_idle_ch got=%b exp=1100", ch_aresetn); end
    checks++; if (master_trigger !== 1'b0) begin failures++; $display("FAIL int_idle_master got=%b exp=0", master_trigger); end
    counter_trigger = 1'b1;
    wait_neg(1);
    checks++; if (ch_aresetn !== 4'b1100) begin failures++; $display("FAIL int_early_ch got=%b exp=1100", ch_aresetn); end
    checks++; if (master_trigger !== 1'b0) begin failures++; $display("FAIL int_early_master got=%b exp=0", master_trigger); end
    wait_neg(1);
    checks++; if (ch_aresetn !== 4'b1111) begin failures++; $display("FAIL int_ch got=%b exp=1111", ch_aresetn); end
    checks++; if (master_trigger !== 1'b1) begin failures++; $display("FAIL int_master got=%b exp=1", master_trigger); end
    cfg_trigger_enable = 1'b0;
    wait_neg(1);
    checks++; if (master_trigger !== 1'b1) begin failures++; $display("FAIL dis_master_early got=%b exp=1", master_trigger); end
    wait_neg(1);
    checks++; if (master_trigger !== 1'b0) begin failures++; $display("FAIL dis_master got=%b exp=0", master_trigger); end
    checks++; if (ch_aresetn !== 4'b1100) begin failures++; $display("FAIL dis_ch got=%b exp=1100", ch_aresetn); end
    cfg_trigger_mask = 4'b0000;
    wait_neg(2);
  endtask

  task automatic test_heartbeat;
    logic prev;
    logic found;
    int hi;
    int lo;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      prev = alive_signal;
      @(negedge clk);
      if (!prev && alive_signal) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL hb_rise got=%b exp=1", found); end
    hi = 0;
    while (alive_signal === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
    lo = 0;
    while (alive_signal === 1'b0 && lo < 40) begin lo++; @(negedge clk); end
    checks++; if (hi !== 3) begin failures++; $display("FAIL hb_high got=%0d exp=3", hi); end
    checks++; if (lo !== 10) begin failures++; $display("FAIL hb_low got=%0d exp=10", lo); end
    checks++; if (hi + lo !== 13) begin failures++; $display("FAIL hb_period got=%0d exp=13", hi + lo); end
  endtask

  // Last pin toggle at a falling edge: sync after 2 edges, FAULT 100 later
  // (edge 102), reset_ack/channels on edge 103.
  task automatic test_watchdog;
    int ack_seen;
    cfg_fault_mask = 4'b0101;
    cfg_watchdog_enable = 1'b1;
    ack_seen = 0;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (reset_ack !== 1'b0) ack_seen++;
      end
      watchdog_in = ~watchdog_in;
    end
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      if (reset_ack !== 1'b0) ack_seen++;
    end
    checks++; if (ack_seen !== 0) begin failures++; $display("FAIL wd_no_early_fault got=%0d exp=0", ack_seen); end
    wait_neg(1);
    checks++; if (reset_ack !== 1'b1) begin failures++; $display("FAIL wd_ack got=%b exp=1", reset_ack); end
    checks++; if (ch_aresetn !== 4'b1010) begin failures++; $display("FAIL wd_ch got=%b exp=1010", ch_aresetn); end
    checks++; if (status[6:5] !== 2'b01) begin failures++; $display("FAIL wd_cause got=%b exp=01", status[6:5]); end
    checks++; if (status[1:0] !== 2'd3) begin failures++; $display("FAIL wd_state got=%0d exp=3", status[1:0]); end
    cfg_watchdog_enable = 1'b0;
    wait_neg(5);
    checks++; if (reset_ack !== 1'b1) begin failures++; $display("FAIL wd_latched got=%b exp=1", reset_ack); end
    cfg_fault_clear = 1'b1;
    wait_neg(2);
    checks++; if (ch_aresetn !== 4'b1010) begin failures++; $display("FAIL clr_early_ch got=%b exp=1010", ch_aresetn); end
    wait_neg(1);
    checks++; if (ch_aresetn !== 4'b1111) begin failures++; $display("FAIL clr_ch got=%b exp=1111", ch_aresetn); end
    checks++; if (reset_ack !== 1'b0) begin failures++; $display("FAIL clr_ack got=%b exp=0", reset_ack); end
    checks++; if (status[6:5] !== 2'b00) begin failures++; $display("FAIL clr_cause got=%b exp=00", status[6:5]); end
    cfg_fault_clear = 1'b0;
  endtask

  // Watchdog toggle and instant-reset pulse timed so both fire on edge 102.
  task automatic test_instant;
    cfg_watchdog_enable = 1'b1;
    cfg_instant_reset_enable = 1'b1;
    watchdog_in = ~watchdog_in;
    wait_neg(99);
    instant_reset_in = 1'b1;
    wait_neg(3);
    checks++; if (reset_ack !== 1'b0) begin failures++; $display("FAIL both_early_ack got=%b exp=0", reset_ack); end
    wait_neg(1);
    checks++; if (reset_ack !== 1'b1) begin failures++; $display("FAIL both_ack got=%b exp=1", reset_ack); end
    checks++; if (status[6:5] !== 2'b11) begin failures++; $display("FAIL both_cause got=%b exp=11", status[6:5]); end
    checks++; if (ch_aresetn !== 4'b1010) begin failures++; $display("FAIL both_ch got=%b exp=1010", ch_aresetn); end
    cfg_watchdog_enable = 1'b0;
    cfg_fault_clear = 1'b1;
    wait_neg(5);
    checks++; if (reset_ack !== 1'b1) begin failures++; $display("FAIL clr_blocked got=%b exp=1", reset_ack); end
    cfg_fault_clear = 1'b0;
    instant_reset_in = 1'b0;
    wait_neg(4);
    cfg_fault_clear = 1'b1;
    wait_neg(2);
    checks++; if (reset_ack !== 1'b1) begin failures++; $display("FAIL ir_clr_early got=%b exp=1", reset_ack); end
    wait_neg(1);
    checks++; if (reset_ack !== 1'b0) begin failures++; $display("FAIL ir_clr_ack got=%b exp=0", reset_ack); end
    checks++; if (ch_aresetn !== 4'b1111) begin failures++; $display("FAIL ir_clr_ch got=%b exp=1111", ch_aresetn); end
    checks++; if (status[6:5] !== 2'b00) begin failures++; $display("FAIL ir_clr_cause got=%b exp=00", status[6:5]); end
    cfg_fault_clear = 1'b0;
  endtask

  task automatic test_reset_mid_fault;
    cfg_trigger_enable = 1'b1;
    instant_reset_in = 1'b1;
    wait_neg(5);
    checks++; if (reset_ack !== 1'b1) begin failures++; $display("FAIL mid_fault got=%b exp=1", reset_ack); end
    checks++; if (master_trigger !== 1'b1) begin failures++; $display("FAIL mid_master got=%b exp=1", master_trigger); end
    #2;
    peripheral_aresetn = 1'b0;
    #1;
    checks++; if (ch_aresetn !== 4'b0000) begin failures++; $display("FAIL mid_rst_ch got=%b exp=0000", ch_aresetn); end
    checks++; if (reset_ack !== 1'b0) begin failures++; $display("FAIL mid_rst_ack got=%b exp=0", reset_ack); end
    checks++; if (master_trigger !== 1'b0) begin failures++; $display("FAIL mid_rst_master got=%b exp=0", master_trigger); end
    checks++; if (status !== 32'd0) begin failures++; $display("FAIL mid_rst_status got=%h exp=00000000", status); end
    instant_reset_in = 1'b0;
    cfg_instant_reset_enable = 1'b0;
    wait_neg(2);
    peripheral_aresetn = 1'b1;
    wait_neg(3);
    checks++; if (ch_aresetn !== 4'b0000) begin failures++; $display("FAIL rerun_early got=%b exp=0000", ch_aresetn); end
    wait_neg(1);
    checks++; if (ch_aresetn !== 4'b0001) begin failures++; $display("FAIL rerun_ch0 got=%b exp=0001", ch_aresetn); end
    checks++; if (status[6:5] !== 2'b00) begin failures++; $display("FAIL rerun_cause got=%b exp=00", status[6:5]); end
    checks++; if (status[1:0] !== 2'd1) begin failures++; $display("FAIL rerun_state got=%0d exp=1", status[1:0]); end
    wait_neg(47);
    checks++; if (ch_aresetn !== 4'b0111) begin failures++; $display("FAIL rerun_ch2 got=%b exp=0111", ch_aresetn); end
    wait_neg(1);
    checks++; if (ch_aresetn !== 4'b1111) begin failures++; $display("FAIL rerun_all got=%b exp=1111", ch_aresetn); end
  endtask

  initial begin
    test_reset();
    test_stagger();
    test_trigger_ext();
    test_trigger_int();
    test_heartbeat();
    test_watchdog();
    test_instant();
    test_reset_mid_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
